fp_bcd_format: RTL and testbench

Sequential binary-to-BCD formatter directly downstream of the positive-exponent float-to-decimal ALU. It captures that stage's three results and converts them into packed BCD digits for the display/print path:

- integer part `nguyen`
- fractional digits `le`
- signed power-of-ten exponent `lt`

It uses three parallel serial double-dabble engines under a start/busy/done handshake.

---
 rtl/fp_bcd_format.sv | 198 +++++++++++++++++++
 tb/tb_fp_bcd_format.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_bcd_format.sv
// fp_bcd_format: converts the float-to-decimal ALU results (integer part,
// fractional digits, signed exponent) into packed BCD. Three serial
// double-dabble engines run in parallel under a start/busy/done handshake.
// The latency is a fixed 20 cycles.
module fp_bcd_format (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [4:0]  nguyen,
    input  logic [19:0] le,
    input  logic [8:0]  lt,
    output logic        busy,
    output logic        done,
    output logic [7:0]  int_bcd,
    output logic [23:0] frac_bcd,
    output logic        exp_sign,
    output logic [11:0] exp_bcd,
    output logic        err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    // The widest engine (frac) needs 20 steps, numbered 0..19.
    localparam logic [4:0] LAST_STEP = 5'd19;
    localparam logic [4:0] INT_STEPS = 5'd5;
    localparam logic [4:0] EXP_STEPS = 5'd9;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;

    // Binary shift registers; the MSB feeds the BCD accumulator.
    logic [4:0]  int_bin_reg, int_bin_next;
    logic [19:0] frac_bin_reg, frac_bin_next;
    logic [8:0]  exp_bin_reg, exp_bin_next;
    logic        sign_reg, sign_next;

    // BCD accumulators. frac carries a seventh (guard) digit that detects
    // inputs above 999999.
    logic [7:0]  int_acc_reg, int_acc_next;
    logic [27:0] frac_acc_reg, frac_acc_next;
    logic [11:0] exp_acc_reg, exp_acc_next;

    // Registered outputs.
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [7:0]  int_bcd_reg, int_bcd_next;
    logic [23:0] frac_bcd_reg, frac_bcd_next;
    logic        exp_sign_reg, exp_sign_next;
    logic [11:0] exp_bcd_reg, exp_bcd_next;
    logic        err_reg, err_next;

    // Accumulators after the add-3 correction. The shift is applied in the
    // next-state logic.
    logic [7:0]  int_adj;
    logic [27:0] frac_adj;
    logic [11:0] exp_adj;
    logic [8:0]  lt_abs;

    // Two's-complement magnitude. -256 maps to 9'h100, which still fits as
    // an unsigned 9-bit value.
    assign lt_abs = lt[8] ? (~lt + 9'd1) : lt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_int_adj
            assign int_adj[gi*4 +: 4] = (int_acc_reg[gi*4 +: 4] >= 4'd5)
                                      ? int_acc_reg[gi*4 +: 4] + 4'd3
                                      : int_acc_reg[gi*4 +: 4];
        end
        for (gi = 0; gi < 7; gi++) begin : g_frac_adj
            assign frac_adj[gi*4 +: 4] = (frac_acc_reg[gi*4 +: 4] >= 4'd5)
                                       ? frac_acc_reg[gi*4 +: 4] + 4'd3
                                       : frac_acc_reg[gi*4 +: 4];
        end
        for (gi = 0; gi < 3; gi++) begin : g_exp_adj
            assign exp_adj[gi*4 +: 4] = (exp_acc_reg[gi*4 +: 4] >= 4'd5)
                                      ? exp_acc_reg[gi*4 +: 4] + 4'd3
                                      : exp_acc_reg[gi*4 +: 4];
        end
    endgenerate

    // Next-state logic: input capture, per-engine stepping and result load.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        int_bin_next  = int_bin_reg;
        frac_bin_next = frac_bin_reg;
        exp_bin_next  = exp_bin_reg;
        sign_next     = sign_reg;
        int_acc_next  = int_acc_reg;
        frac_acc_next = frac_acc_reg;
        exp_acc_next  = exp_acc_reg;
        done_next     = 1'b0;
        int_bcd_next  = int_bcd_reg;
        frac_bcd_next = frac_bcd_reg;
        exp_sign_next = exp_sign_reg;
        exp_bcd_next  = exp_bcd_reg;
        err_next      = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    int_bin_next  = nguyen;
                    frac_bin_next = le;
                    exp_bin_next  = lt_abs;
                    sign_next     = lt[8];
                    int_acc_next  = '0;
                    frac_acc_next = '0;
                    exp_acc_next  = '0;
                    cnt_next      = '0;
                    state_next    = ST_CONV;
                end
            end
            ST_CONV: begin
                if (cnt_reg < INT_STEPS) begin
                    int_acc_next = {int_adj[6:0], int_bin_reg[4]};
                    int_bin_next = {int_bin_reg[3:0], 1'b0};
                end
                if (cnt_reg < EXP_STEPS) begin
                    exp_acc_next = {exp_adj[10:0], exp_bin_reg[8]};
                    exp_bin_next = {exp_bin_reg[7:0], 1'b0};
                end
                frac_acc_next = {frac_adj[26:0], frac_bin_reg[19]};
                frac_bin_next = {frac_bin_reg[18:0], 1'b0};
                cnt_next      = cnt_reg + 5'd1;

                if (cnt_reg == LAST_STEP) begin
                    int_bcd_next  = int_acc_next;
                    exp_bcd_next  = exp_acc_next;
                    exp_sign_next = sign_reg;
                    if (frac_acc_next[27:24] != 4'd0) begin
                        frac_bcd_next = 24'h999999;
                        err_next      = 1'b1;
                    end else begin
                        frac_bcd_next = frac_acc_next[23:0];
                        err_next      = 1'b0;
                    end
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next == ST_CONV);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            int_bin_reg  <= '0;
            frac_bin_reg <= '0;
            exp_bin_reg  <= '0;
            sign_reg     <= 1'b0;
            int_acc_reg  <= '0;
            frac_acc_reg <= '0;
            exp_acc_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            int_bcd_reg  <= '0;
            frac_bcd_reg <= '0;
            exp_sign_reg <= 1'b0;
            exp_bcd_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            int_bin_reg  <= int_bin_next;
            frac_bin_reg <= frac_bin_next;
            exp_bin_reg  <= exp_bin_next;
            sign_reg     <= sign_next;
            int_acc_reg  <= int_acc_next;
            frac_acc_reg <= frac_acc_next;
            exp_acc_reg  <= exp_acc_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            int_bcd_reg  <= int_bcd_next;
            frac_bcd_reg <= frac_bcd_next;
            exp_sign_reg <= exp_sign_next;
            exp_bcd_reg  <= exp_bcd_next;
            err_reg      <= err_next;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign int_bcd  = int_bcd_reg;
    assign frac_bcd = frac_bcd_reg;
    assign exp_sign = exp_sign_reg;
    assign exp_bcd  = exp_bcd_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_fp_bcd_format.sv
// Testbench for fp_bcd_format: directed and random conversions compared
// against a decimal-arithmetic reference model.
module tb_fp_bcd_format;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [4:0]  nguyen;
    logic [19:0] le;
    logic [8:0]  lt;
    logic        busy;
    logic        done;
    logic [7:0]  int_bcd;
    logic [23:0] frac_bcd;
    logic        exp_sign;
    logic [11:0] exp_bcd;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    fp_bcd_format dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .nguyen   (nguyen),
        .le       (le),
        .lt       (lt),
        .busy     (busy),
        .done     (done),
        .int_bcd  (int_bcd),
        .frac_bcd (frac_bcd),
        .exp_sign (exp_sign),
        .exp_bcd  (exp_bcd),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: decimal digits by repeated division.
    function automatic logic [31:0] dec_digits(input int unsigned v, input int nd);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < nd; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check_outputs(input string pfx, input logic [4:0] n,
                                 input logic [19:0] l, input logic [8:0] t);
        int unsigned lv;
        int          ts;
        int unsigned ta;
        bit          sat;
        lv  = 32'(l);
        sat = (lv > 999999);
        ts  = int'($signed(t));
        ta  = (ts < 0) ? 32'(-ts) : 32'(ts);
        check({pfx, "_int_bcd"},  32'(int_bcd),  dec_digits(32'(n), 2));
        check({pfx, "_frac_bcd"}, 32'(frac_bcd), sat ? 32'h999999 : dec_digits(lv, 6));
        check({pfx, "_err"},      32'(err),      32'(sat));
        check({pfx, "_exp_sign"}, 32'(exp_sign), 32'(ts < 0));
        check({pfx, "_exp_bcd"},  32'(exp_bcd),  dec_digits(ta, 3));
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"},     32'(busy),     32'd0);
        check({pfx, "_done"},     32'(done),     32'd0);
        check({pfx, "_int_bcd"},  32'(int_bcd),  32'd0);
        check({pfx, "_frac_bcd"}, 32'(frac_bcd), 32'd0);
        check({pfx, "_exp_sign"}, 32'(exp_sign), 32'd0);
        check({pfx, "_exp_bcd"},  32'(exp_bcd),  32'd0);
        check({pfx, "_err"},      32'(err),      32'd0);
    endtask

    // Called at a negedge: presents inputs and raises start for the next edge.
    task automatic begin_start(input logic [4:0] n, input logic [19:0] l, input logic [8:0] t);
        nguyen = n;
        le     = l;
        lt     = t;
        start  = 1'b1;
    endtask

    // Follows one conversion from its accepting edge to the done cycle.
    // A start pulse is injected after busy edge 'inject' (negative: none).
    task automatic follow(input string pfx, input logic [4:0] n, input logic [19:0] l,
                          input logic [8:0] t, input int inject);
        logic [7:0]  hold_int;
        logic [23:0] hold_frac;
        @(negedge CLK);
        start  = 1'b0;
        nguyen = 5'($urandom);
        le     = 20'($urandom);
        lt     = 9'($urandom);
        hold_int  = int_bcd;
        hold_frac = frac_bcd;
        check({pfx, "_busy_rise"}, 32'(busy), 32'd1);
        check({pfx, "_done_low"},  32'(done), 32'd0);
        for (int k = 1; k < 20; k++) begin
            @(negedge CLK);
            if (k == inject) begin
                start  = 1'b1;
                nguyen = 5'($urandom);
                le     = 20'($urandom);
                lt     = 9'($urandom);
            end else begin
                start = 1'b0;
            end
            check({pfx, "_busy_hold"}, 32'(busy), 32'd1);
            check({pfx, "_no_early_done"}, 32'(done), 32'd0);
            if (k == 10) begin
                check({pfx, "_int_held"},  32'(int_bcd),  32'(hold_int));
                check({pfx, "_frac_held"}, 32'(frac_bcd), 32'(hold_frac));
            end
        end
        @(negedge CLK);
        start = 1'b0;
        check({pfx, "_done_pulse"}, 32'(done), 32'd1);
        check({pfx, "_busy_fall"},  32'(busy), 32'd0);
        check_outputs(pfx, n, l, t);
    endtask

    logic [4:0]  rn;
    logic [19:0] rl;
    logic [8:0]  rt;

    initial begin
        RST    = 1'b1;
        start  = 1'b1;
        nguyen = 5'd17;
        le     = 20'd4242;
        lt     = 9'd77;

        // Reset held for two edges with start high.
        repeat (2) begin
            @(negedge CLK);
            check_zero("reset");
        end
        RST   = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check_zero("post_reset");
        end

        // Nominal conversion.
        begin_start(5'd3, 20'd141592, 9'd0);
        follow("nominal", 5'd3, 20'd141592, 9'd0, -1);
        check("nominal_frac_const", 32'(frac_bcd), 32'h141592);
        check("nominal_int_const",  32'(int_bcd),  32'h03);
        @(negedge CLK);
        check("nominal_done_fall", 32'(done), 32'd0);
        check("nominal_idle",      32'(busy), 32'd0);

        // Exponent and integer extremes.
        begin_start(5'd31, 20'd0, 9'h100);
        follow("exp_min", 5'd31, 20'd0, 9'h100, -1);
        check("exp_min_const", 32'(exp_bcd), 32'h256);
        check("int_max_const", 32'(int_bcd), 32'h31);
        @(negedge CLK);
        begin_start(5'd31, 20'd0, 9'd255);
        follow("exp_max", 5'd31, 20'd0, 9'd255, -1);
        check("exp_max_const", 32'(exp_bcd), 32'h255);
        @(negedge CLK);

        // Fraction saturation, then the largest legal fraction.
        begin_start(5'd0, 20'hFFFFF, 9'd0);
        follow("sat", 5'd0, 20'hFFFFF, 9'd0, -1);
        check("sat_err_const", 32'(err), 32'd1);
        @(negedge CLK);
        begin_start(5'd0, 20'd999999, 9'd0);
        follow("max_legal", 5'd0, 20'd999999, 9'd0, -1);
        check("max_legal_err_const", 32'(err), 32'd0);
        @(negedge CLK);

        // start during busy is ignored and not queued.
        begin_start(5'd7, 20'd123456, 9'h1FB);
        follow("ignore", 5'd7, 20'd123456, 9'h1FB, 5);
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            check("ignore_no_second_done", 32'(done), 32'd0);
            check("ignore_stays_idle",     32'(busy), 32'd0);
        end

        // start held in the done cycle launches the next conversion.
        begin_start(5'd12, 20'd98765, 9'd42);
        follow("chain_a", 5'd12, 20'd98765, 9'd42, -1);
        begin_start(5'd25, 20'd500001, 9'h180);
        follow("chain_b", 5'd25, 20'd500001, 9'h180, -1);
        @(negedge CLK);
        check("chain_done_fall", 32'(done), 32'd0);

        // Reset in the middle of a conversion.
        begin_start(5'd9, 20'd777777, 9'd100);
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_zero("midreset");
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            check("midreset_no_done", 32'(done), 32'd0);
            check("midreset_idle",    32'(busy), 32'd0);
        end
        begin_start(5'd4, 20'd271828, 9'h1FF);
        follow("after_reset", 5'd4, 20'd271828, 9'h1FF, -1);
        @(negedge CLK);

        // Random conversions, some back-to-back, some with an idle gap.
        for (int i = 0; i < 30; i++) begin
            rn = 5'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'($urandom_range(0, 999999));
            rt = 9'($urandom);
            begin_start(rn, rl, rt);
            follow("random", rn, rl, rt, -1);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge CLK);
                check("random_done_fall", 32'(done), 32'd0);
                check("random_idle",      32'(busy), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
